// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states,
// immediate-format select, RV64 opcodes and the canonical NOP.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3
  } imm_sel_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_detect.sv
// ID-stage decode: source-register usage, load-use hazard and immediate select.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rd_i,
  output logic        lu_o,
  output imm_sel_e    imm_sel_o
);

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       use_rs1;
  logic       use_rs2;
  logic       unused_instr_bits;

  assign opcode = instr_i[6:0];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign unused_instr_bits = ^{instr_i[31:25], instr_i[14:7]};

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    imm_sel_o = IMM_NONE;
    unique case (opcode)
      OP_R:      begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IMM:    begin use_rs1 = 1'b1; imm_sel_o = IMM_I; end
      OP_LOAD:   begin use_rs1 = 1'b1; imm_sel_o = IMM_I; end
      OP_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel_o = IMM_S; end
      OP_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel_o = IMM_B; end
      default:   ;
    endcase
  end

  assign lu_o = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                ((use_rs1 && (ex_rd_i == rs1)) || (use_rs2 && (ex_rd_i == rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/freeze decisions, memory-wait
// FSM with timeout fault. Optional counters under PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WAIT_W   = 5
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [31:0] id_instr_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        hold_o,
  output logic        wb_bubble_o,
  output logic [2:0]  imm_sel_o,
`ifdef PIPE_HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic        err_o,
  output logic [1:0]  state_o
);

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              lu;
  logic              mw;
  logic              flush_evt;
  imm_sel_e          imm_sel;

  hazard_detect u_hazard_detect (
    .instr_i       (id_instr_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_i       (ex_rd_i),
    .lu_o          (lu),
    .imm_sel_o     (imm_sel)
  );

  assign imm_sel_o = imm_sel;
  assign mw        = mem_req_i && !mem_ready_i;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    hold_o        = 1'b0;
    wb_bubble_o   = 1'b0;
    flush_evt     = 1'b0;

    // The first not-ready cycle is seen in RUN, so the counter already
    // holds the number of elapsed not-ready cycles once the edge lands.
    if ((state_q == ST_FAULT) ||
        ((state_q == ST_RUN) && mw) ||
        ((state_q == ST_MEM_WAIT) && !mem_ready_i)) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      hold_o       = 1'b1;
      wb_bubble_o  = 1'b1;
      if (state_q == ST_RUN) cnt_d = WAIT_W'(1);
      else if (state_q == ST_MEM_WAIT) cnt_d = cnt_q + WAIT_W'(1);
      if (state_q == ST_FAULT || cnt_d == MaxWait) state_d = ST_FAULT;
      else state_d = ST_MEM_WAIT;
    end else begin
      if (ex_branch_taken_i) begin
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
        flush_evt     = 1'b1;
      end else if (lu) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end
      state_d = ST_RUN;
      cnt_d   = '0;
    end

    if (state_d == ST_FAULT) err_d = 1'b1;

    if (!rst_n) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      hold_o        = 1'b0;
      wb_bubble_o   = 1'b1;
      flush_evt     = 1'b0;
    end
  end

  assign err_o   = err_q;
  assign state_o = state_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_o && (state_q != ST_FAULT) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_evt && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_flush_evt;
  assign unused_flush_evt = flush_evt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MAX_WAIT=4); perf counters checked
// when PIPE_HAZARD_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, hold, wb_bubble;
  logic [2:0]  imm_sel;
  logic        err;
  logic [1:0]  state;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] ADD_X7_X5_X6  = 32'h0062_83B3;
  localparam logic [31:0] ADDI_X7_X3_4  = 32'h0041_8393;
  localparam logic [31:0] SW_X5_0_X2    = 32'h0051_2023;
  localparam logic [31:0] BEQ_X5_X6     = 32'h0062_8063;
  localparam logic [31:0] LD_X9_0_X5    = 32'h0002_B483;
  localparam logic [31:0] LUI_X5        = 32'h0000_52B7;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, hold, wb_bubble}
  localparam logic [5:0] C_RUN    = 6'b110000;
  localparam logic [5:0] C_RESET  = 6'b001101;
  localparam logic [5:0] C_STALL  = 6'b000100;
  localparam logic [5:0] C_FLUSH  = 6'b111100;
  localparam logic [5:0] C_FREEZE = 6'b000011;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MAX_WAIT(4), .WAIT_W(5)) dut (
    .clk_i             (clk),
    .rst_n             (rst_n),
    .id_instr_i        (id_instr),
    .ex_mem_read_i     (ex_mem_read),
    .ex_rd_i           (ex_rd),
    .ex_branch_taken_i (ex_branch_taken),
    .mem_req_i         (mem_req),
    .mem_ready_i       (mem_ready),
    .pc_write_o        (pc_write),
    .ifid_write_o      (ifid_write),
    .ifid_flush_o      (ifid_flush),
    .idex_bubble_o     (idex_bubble),
    .hold_o            (hold),
    .wb_bubble_o       (wb_bubble),
    .imm_sel_o         (imm_sel),
`ifdef PIPE_HAZARD_PERF_CNT_EN
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt),
`endif
    .err_o             (err),
    .state_o           (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, pc_write, ifid_write, ifid_flush, idex_bubble, hold, wb_bubble}, {26'd0, exp});
  endtask

  // Advance one rising edge; inputs are driven right after the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    id_instr = ADD_X7_X5_X6; ex_mem_read = 0; ex_rd = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    id_instr = ADDI_X7_X3_4;
    #1;
    chk_ctl("reset_ctl", C_RESET);
    chk("reset_state", state, 0);
    chk("reset_err", err, 0);
    chk("reset_imm_follows", imm_sel, 1);
    step(); step();
    rst_n = 1; idle();
    #1;
    chk_ctl("run_idle", C_RUN);

    ex_mem_read = 1; ex_rd = 5;
    #1; chk_ctl("lu_rs1", C_STALL);
    step(); ex_mem_read = 0;
    #1; chk_ctl("lu_cleared", C_RUN);
    chk("lu_state", state, 0);

    ex_mem_read = 1; ex_rd = 6;
    #1; chk_ctl("lu_rs2", C_STALL);
    ex_rd = 0;
    #1; chk_ctl("lu_x0", C_RUN);
    id_instr = ADDI_X7_X3_4; ex_rd = 4;
    #1; chk_ctl("lu_i_rs2_unused", C_RUN);
    ex_rd = 3;
    #1; chk_ctl("lu_i_rs1", C_STALL);
    id_instr = LUI_X5; ex_rd = 5;
    #1; chk_ctl("lu_lui_none", C_RUN);
    id_instr = ADD_X7_X5_X6; ex_rd = 5; ex_branch_taken = 1;
    #1; chk_ctl("branch_over_lu", C_FLUSH);
    step(); idle();

    mem_req = 1; mem_ready = 0;
    #1; chk_ctl("mw_run", C_FREEZE);
    chk("mw_run_state", state, 0);
    step(); #1;
    chk("mw_state1", state, 1);
    chk_ctl("mw_freeze1", C_FREEZE);
    step(); #1;
    chk_ctl("mw_freeze2", C_FREEZE);
    mem_ready = 1; ex_branch_taken = 1;
    #1; chk_ctl("mw_exit_branch", C_FLUSH);
    chk("mw_exit_state", state, 1);
    step(); idle(); #1;
    chk("mw_back_run", state, 0);
    chk("mw_no_err", err, 0);
    chk_ctl("mw_after", C_RUN);

    mem_req = 1; mem_ready = 0;
    step(); step(); step(); #1;
    chk("to_state_wait3", state, 1);
    chk("to_err_wait3", err, 0);
    step(); #1;
    chk("to_fault", state, 2);
    chk("to_err", err, 1);
    chk_ctl("to_fault_ctl", C_FREEZE);
    mem_req = 0; mem_ready = 1;
    step(); #1;
    chk("fault_sticky_state", state, 2);
    chk("fault_sticky_err", err, 1);
    #2 rst_n = 0; #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_err", err, 0);
    chk_ctl("async_rst_ctl", C_RESET);
    #1 rst_n = 1;
    step(); idle(); #1;
    chk_ctl("post_fault_run", C_RUN);

    id_instr = SW_X5_0_X2; #1; chk("imm_s", imm_sel, 2);
    id_instr = BEQ_X5_X6;  #1; chk("imm_b", imm_sel, 3);
    id_instr = ADD_X7_X5_X6; #1; chk("imm_r", imm_sel, 0);
    id_instr = LD_X9_0_X5; #1; chk("imm_load", imm_sel, 1);
    id_instr = LUI_X5;     #1; chk("imm_lui", imm_sel, 0);

`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("perf_stall_zero", stall_cnt, 0);
    chk("perf_flush_zero", flush_cnt, 0);
    idle(); ex_mem_read = 1; ex_rd = 5;
    step(); ex_mem_read = 0;
    step(); ex_mem_read = 1; ex_rd = 6;
    step(); ex_mem_read = 0; ex_branch_taken = 1;
    step(); idle();
    step(); #1;
    chk("perf_stall", stall_cnt, 2);
    chk("perf_flush", flush_cnt, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage 64-bit RISC-V core. It sits beside the ID stage and decides each cycle whether the PC and pipeline registers advance, stall, squash or freeze. It covers load-use hazards, taken branches resolved in EX, and multi-cycle data-memory waits with a timeout fault. It also produces the immediate-format select consumed by the ID-stage immediate generator.

## Interface
- `MAX_WAIT`, default 16: maximum consecutive MEM_WAIT cycles before FAULT, range 1..2^WAIT_W-1.
- `WAIT_W`, default 5: width of the wait counter.
- `clk_i`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_instr_i`  in  32  instruction in IF/ID.
- `ex_mem_read_i`  in  1  EX-stage instruction is a load (ld).
- `ex_rd_i`  in  5  EX-stage destination register.
- `ex_branch_taken_i`  in  1  beq in EX resolved taken.
- `mem_req_i`  in  1  MEM-stage instruction accesses data memory (ld/sd).
- `mem_ready_i`  in  1  data memory completes the access this cycle.
- `pc_write_o`  out  1  PC loads its next value.
- `ifid_write_o`  out  1  IF/ID loads.
- `ifid_flush_o`  out  1  IF/ID loads a NOP.
- `idex_bubble_o`  out  1  ID/EX loads a NOP (control bits zero).
- `hold_o`  out  1  freeze ID/EX and EX/MEM.
- `wb_bubble_o`  out  1  MEM/WB loads a NOP.
- `imm_sel_o`  out  3  0 NONE, 1 I, 2 S, 3 B.
- `err_o`  out  1  sticky memory-timeout fault.
- `state_o`  out  2  0 RUN, 1 MEM_WAIT, 2 FAULT.

## Operation
- `imm_sel_o` is combinational from opcode `id_instr_i[6:0]`:
  - 0010011 or 0000011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - Others, including R-type 0110011 → NONE.
- Source-register use:
  - rs1 (`[19:15]`) is used by opcodes 0110011, 0010011, 0000011, 0100011 and 1100011.
  - rs2 (`[24:20]`) is used by 0110011, 0100011 and 1100011.
- Load-use hazard (`lu`): `ex_mem_read_i` is high, `ex_rd_i` is not 0, and `ex_rd_i` equals a used rs1 or a used rs2.
- Mem-wait condition (`mw`): `mem_req_i` is high and `mem_ready_i` is low.
- Default outputs (RUN, no event): `pc_write_o`=1, `ifid_write_o`=1, all other control outputs 0.
- RUN resolves events in priority order, one per cycle:
  1. `mw`: `pc_write_o`=0, `ifid_write_o`=0, `hold_o`=1, `wb_bubble_o`=1. Next state MEM_WAIT. Wait counter loads 1.
  2. `ex_branch_taken_i`: `pc_write_o`=1 (PC takes the target), `ifid_flush_o`=1, `idex_bubble_o`=1. Any `lu` this cycle is ignored because the ID instruction is squashed.
  3. `lu`: `pc_write_o`=0, `ifid_write_o`=0, `idex_bubble_o`=1. Exactly one bubble; the next cycle the load is in MEM and `lu` clears.
- MEM_WAIT:
  - While `mem_ready_i` is low: outputs are identical to case 1 and the counter increments.
  - When the counter equals `MAX_WAIT` with `mem_ready_i` still low: go to FAULT.
  - When `mem_ready_i`=1: outputs revert to RUN evaluation of branch/`lu` (the `mw` term is masked this cycle), next state RUN, counter cleared.
  - EX is frozen during the wait, so a taken branch held in EX acts on the exit cycle.
- FAULT:
  - `err_o`=1; `pc_write_o`=0, `ifid_write_o`=0, `hold_o`=1, `wb_bubble_o`=1.
  - Only reset exits FAULT.
- Reset:
  - While `rst_n`=0: state RUN, counter 0, `err_o`=0, `pc_write_o`=0, `ifid_write_o`=0, `ifid_flush_o`=1, `idex_bubble_o`=1, `hold_o`=0, `wb_bubble_o`=1.
  - `imm_sel_o` still follows `id_instr_i`.
  - Reset mid-wait or in FAULT aborts immediately and asynchronously.

## Timing
- Control outputs are combinational from registered state plus current inputs. Stall, flush and freeze take effect on the same edge the condition is seen.
- State, wait counter and `err_o` update on the rising edge of `clk_i`.
- Load-use costs exactly 1 cycle; a taken branch costs 2 squashed slots in 1 cycle; a memory wait of N not-ready cycles costs N cycles.
- `MAX_WAIT`=16: the 16th consecutive not-ready cycle enters FAULT on the next edge.

## Configuration
- `PIPE_HAZARD_PERF_CNT_EN` defined:
  - Adds outputs `stall_cnt_o[31:0]` (increments on every cycle with `pc_write_o`=0 in RUN/MEM_WAIT) and `flush_cnt_o[31:0]` (increments on every taken-branch flush).
  - Both counters saturate at 2^32-1 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - The state encoding (RUN/MEM_WAIT/FAULT).
  - The `imm_sel` encoding (NONE/I/S/B).
  - Opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH.
  - The NOP instruction value.
- One sub-module, `hazard_detect`: combinational `lu`, rs1/rs2 usage decode and `imm_sel`.
- The FSM, wait counter and performance counters live in the top module.

## Test plan
- `ex_mem_read_i`=1, `ex_rd_i`=5, ID holds add x7,x5,x6 → one cycle with `pc_write_o`=0, `ifid_write_o`=0, `idex_bubble_o`=1, then normal flow.
- Same load with `ex_rd_i`=0, or ID holds addi x7,x3,4 → no stall.
- `ex_branch_taken_i`=1 together with a load-use condition → `ifid_flush_o`=1, `idex_bubble_o`=1, `pc_write_o`=1, no stall.
- `mem_req_i`=1, `mem_ready_i` low for 3 cycles then high → `hold_o`=1 for 3 cycles, `state_o`=1, return to RUN, `err_o`=0.
- `mem_ready_i` held low with `MAX_WAIT`=4 → FAULT after 4 wait cycles, `err_o`=1 sticky; `rst_n` pulse mid-FAULT → RUN, `err_o`=0.
- `imm_sel_o` for opcodes 0100011 → 2, 1100011 → 3, 0110011 → 0; with `PIPE_HAZARD_PERF_CNT_EN`, 2 load-use stalls plus 1 flush → `stall_cnt_o`=2, `flush_cnt_o`=1.
